cmd_tx: RTL and testbench

CMD_TX -- requirements
Module: cmd_tx

---
 rtl/cmd_tx_pkg.sv | 36 +++
 rtl/cmd_tx_if.sv | 25 ++
 rtl/cmd_tx_dec.sv | 72 +++++++
 rtl/cmd_tx.sv | 141 ++++++++++++++
 tb/tb_cmd_tx.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_tx_pkg.sv
// Shared types and constants for the cmd_tx ASCII command encoder.
// Covers the command/state enums, ASCII bytes and the decimal power-of-ten table.
package cmd_tx_pkg;

  typedef enum logic [1:0] {
    CT_BIN  = 2'b00,
    CT_FLT  = 2'b01,
    CT_TICK = 2'b10,
    CT_RSV  = 2'b11
  } cmd_type_e;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_SP1, S_ID1, S_ID0, S_SP2, S_IDX, S_SP3, S_VBIN, S_VDEC, S_NL
  } state_e;

  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_NL = 8'h0A;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_B  = 8'h62;
  localparam logic [7:0] ASC_F  = 8'h66;
  localparam logic [7:0] ASC_T  = 8'h74;

  localparam int DEC_DIGITS = 5;
  localparam logic [15:0] POW10 [DEC_DIGITS] = '{16'd10000, 16'd1000, 16'd100, 16'd10, 16'd1};

  // Position of the most significant non-zero digit; value 0 starts at the units digit.
  function automatic logic [2:0] dec_first_pos(input logic [15:0] v);
    logic [2:0] p;
    p = 3'(DEC_DIGITS - 1);
    for (int i = DEC_DIGITS - 1; i >= 0; i--) begin
      if (v >= POW10[i]) p = 3'(i);
    end
    return p;
  endfunction

endpackage

// File: rtl/cmd_tx_if.sv
// Command and byte-stream signals of cmd_tx. Both channels are valid/ready: a transfer
// happens on a cycle with valid && ready; the producer holds its payload stable until then.
interface cmd_tx_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [1:0]  cmd_id;
  logic [3:0]  cmd_index;
  logic [63:0] cmd_value;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        err;

  modport master (
    output cmd_valid, cmd_type, cmd_id, cmd_index, cmd_value, tx_ready,
    input  cmd_ready, tx_data, tx_valid, busy, err
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_id, cmd_index, cmd_value, tx_ready,
    output cmd_ready, tx_data, tx_valid, busy, err
  );
endinterface

// File: rtl/cmd_tx_dec.sv
// Sequential decimal digit generator: repeated subtraction of powers of ten, MSB digit first,
// no leading zeros. start_i loads a value; each digit is held until digit_ready_i.
module cmd_tx_dec
  import cmd_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [15:0] value_i,
  output logic        digit_valid_o,
  output logic [3:0]  digit_o,
  output logic        last_o,
  input  logic        digit_ready_i
);

  logic [15:0] rem_q, rem_d;
  logic [2:0]  pos_q, pos_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic        dv_q,  dv_d;

  // Starting at the leading digit keeps every digit within nine subtractions plus one compare.
  always_comb begin
    rem_d = rem_q;
    pos_d = pos_q;
    cnt_d = cnt_q;
    run_d = run_q;
    dv_d  = dv_q;
    if (start_i) begin
      rem_d = value_i;
      pos_d = dec_first_pos(value_i);
      cnt_d = 4'd0;
      run_d = 1'b1;
      dv_d  = 1'b0;
    end else if (dv_q) begin
      if (digit_ready_i) begin
        dv_d  = 1'b0;
        cnt_d = 4'd0;
        if (pos_q == 3'(DEC_DIGITS - 1)) run_d = 1'b0;
        else pos_d = pos_q + 3'd1;
      end
    end else if (run_q) begin
      if (rem_q >= POW10[pos_q]) begin
        rem_d = rem_q - POW10[pos_q];
        cnt_d = cnt_q + 4'd1;
      end else begin
        dv_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= 16'd0;
      pos_q <= 3'd0;
      cnt_q <= 4'd0;
      run_q <= 1'b0;
      dv_q  <= 1'b0;
    end else begin
      rem_q <= rem_d;
      pos_q <= pos_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      dv_q  <= dv_d;
    end
  end

  assign digit_valid_o = dv_q;
  assign digit_o       = cnt_q;
  assign last_o        = (pos_q == 3'(DEC_DIGITS - 1));

endmodule

// File: rtl/cmd_tx.sv
// cmd_tx: turns one command into an ASCII frame on a byte stream ("b ..", "f ..", "t").
// Define CMD_TX_FLOAT_EN to build the decimal path and accept 'f' commands.
module cmd_tx
  import cmd_tx_pkg::*;
#(
  parameter int BIN_W = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  cmd_tx_if.slave bus,
  output state_e dbg_state_o
);

  localparam logic [5:0] BIT_TOP = 6'(BIN_W - 1);

  state_e      state_q, state_d;
  logic        rdy_q, err_q, err_d;
  logic [5:0]  bit_q, bit_d;
  cmd_type_e   type_q;
  logic [1:0]  id_q;
  logic [3:0]  idx_q;
  logic [63:0] val_q;

  logic        cmd_ready, accept, legal, hs, tx_valid;
  logic [7:0]  tx_data;
  cmd_type_e   in_type;
  logic        dec_valid, dec_last;
  logic [3:0]  dec_digit;

`ifdef CMD_TX_FLOAT_EN
  localparam logic FLT_OK = 1'b1;
  logic dec_start, dec_ready;
  assign dec_start = (state_q == S_SP3) && hs && (type_q == CT_FLT);
  assign dec_ready = (state_q == S_VDEC) && bus.tx_ready;

  cmd_tx_dec u_dec (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (dec_start),
    .value_i       (val_q[15:0]),
    .digit_valid_o (dec_valid),
    .digit_o       (dec_digit),
    .last_o        (dec_last),
    .digit_ready_i (dec_ready)
  );
`else
  localparam logic FLT_OK = 1'b0;
  assign dec_valid = 1'b0;
  assign dec_digit = 4'd0;
  assign dec_last  = 1'b0;
`endif

  // rdy_q keeps cmd_ready low while reset is held and for the cycle it is released in.
  assign cmd_ready = rdy_q && (state_q == S_IDLE);
  assign accept    = bus.cmd_valid && cmd_ready;
  assign in_type   = cmd_type_e'(bus.cmd_type);
  assign legal     = (bus.cmd_index <= 4'd9) &&
                     ((in_type == CT_BIN) || (in_type == CT_TICK) || (FLT_OK && (in_type == CT_FLT)));

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    err_d    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      S_CMD: begin
        tx_valid = 1'b1;
        tx_data  = (type_q == CT_BIN) ? ASC_B : (type_q == CT_FLT) ? ASC_F : ASC_T;
      end
      S_SP1, S_SP2, S_SP3: begin tx_valid = 1'b1; tx_data = ASC_SP; end
      S_ID1:  begin tx_valid = 1'b1; tx_data = ASC_0 | {7'd0, id_q[1]}; end
      S_ID0:  begin tx_valid = 1'b1; tx_data = ASC_0 | {7'd0, id_q[0]}; end
      S_IDX:  begin tx_valid = 1'b1; tx_data = ASC_0 + {4'd0, idx_q}; end
      S_VBIN: begin tx_valid = 1'b1; tx_data = ASC_0 | {7'd0, val_q[bit_q]}; end
      S_VDEC: begin tx_valid = dec_valid; tx_data = ASC_0 | {4'd0, dec_digit}; end
      S_NL:   begin tx_valid = 1'b1; tx_data = ASC_NL; end
      default: ;
    endcase
    hs = tx_valid && bus.tx_ready;

    case (state_q)
      S_IDLE: if (accept) begin
        if (legal) state_d = S_CMD;
        else       err_d   = 1'b1;
      end
      S_CMD:  if (hs) state_d = (type_q == CT_TICK) ? S_NL : S_SP1;
      S_SP1:  if (hs) state_d = S_ID1;
      S_ID1:  if (hs) state_d = S_ID0;
      S_ID0:  if (hs) state_d = S_SP2;
      S_SP2:  if (hs) state_d = S_IDX;
      S_IDX:  if (hs) state_d = S_SP3;
      S_SP3:  if (hs) begin
        if (type_q == CT_FLT) state_d = S_VDEC;
        else begin
          state_d = S_VBIN;
          bit_d   = BIT_TOP;
        end
      end
      S_VBIN: if (hs) begin
        if (bit_q == 6'd0) state_d = S_NL;
        else               bit_d   = bit_q - 6'd1;
      end
      S_VDEC: if (hs && dec_last) state_d = S_NL;
      S_NL:   if (hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      bit_q   <= 6'd0;
      type_q  <= CT_BIN;
      id_q    <= 2'd0;
      idx_q   <= 4'd0;
      val_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      err_q   <= err_d;
      bit_q   <= bit_d;
      if (accept) begin
        type_q <= in_type;
        id_q   <= bus.cmd_id;
        idx_q  <= bus.cmd_index;
        val_q  <= bus.cmd_value;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.tx_valid  = tx_valid;
  assign bus.tx_data   = tx_data;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.err       = err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_cmd_tx.sv
// Self-checking bench for cmd_tx: expected frame bytes are queued at command time and
// compared as the byte stream transfers them.
module tb_cmd_tx;
  import cmd_tx_pkg::*;

  localparam int BIN_W = 8;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_e dbg_state;

  cmd_tx_if bus();

  cmd_tx #(.BIN_W(BIN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  int ready_mode = 0;
  int err_seen = 0;
  int valid_seen = 0;
  int xfer_cnt = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       bus.tx_ready = ~bus.tx_ready;
        2:       bus.tx_ready = 1'($urandom_range(0, 1));
        default: bus.tx_ready = 1'b1;
      endcase
    end
  end

  task automatic push_frame(input logic [1:0] t, input logic [1:0] id, input logic [3:0] idx,
                            input logic [63:0] v);
    int n;
    int d[$];
    if (t == 2'b10) begin
      exp_q.push_back(8'h74);
      exp_q.push_back(8'h0A);
      return;
    end
    exp_q.push_back((t == 2'b00) ? 8'h62 : 8'h66);
    exp_q.push_back(8'h20);
    exp_q.push_back(id[1] ? 8'h31 : 8'h30);
    exp_q.push_back(id[0] ? 8'h31 : 8'h30);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h30 + 8'(idx));
    exp_q.push_back(8'h20);
    if (t == 2'b00) begin
      for (int i = BIN_W - 1; i >= 0; i--) exp_q.push_back(v[i] ? 8'h31 : 8'h30);
    end else begin
      n = int'(v[15:0]);
      do begin
        d.push_front(n % 10);
        n = n / 10;
      end while (n > 0);
      foreach (d[k]) exp_q.push_back(8'h30 + 8'(d[k]));
    end
    exp_q.push_back(8'h0A);
  endtask

  // Drives a command and returns just after the accepting clock edge.
  task automatic send_cmd(input logic [1:0] t, input logic [1:0] id, input logic [3:0] idx,
                          input logic [63:0] v, input bit expect_ok);
    int n;
    @(negedge clk);
    if (expect_ok) push_frame(t, id, idx, v);
    bus.cmd_valid = 1'b1;
    bus.cmd_type  = t;
    bus.cmd_id    = id;
    bus.cmd_index = idx;
    bus.cmd_value = v;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 64'(n < 200), 64'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.cmd_ready) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(n < budget), 64'd1);
  endtask

  task automatic reject_test(input logic [1:0] t, input logic [3:0] idx, input string tag);
    err_seen = 0;
    valid_seen = 0;
    send_cmd(t, 2'b01, idx, 64'h3, 1'b0);
    repeat (4) @(negedge clk);
    check({tag, "_err_pulses"}, 64'(err_seen), 64'd1);
    check({tag, "_tx_valid"}, 64'(valid_seen), 64'd0);
    check({tag, "_ready"}, 64'(bus.cmd_ready), 64'd1);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.err) err_seen++;
      if (bus.tx_valid) valid_seen++;
      if (prev_stall) begin
        check("stall_valid", 64'(bus.tx_valid), 64'd1);
        check("stall_data", 64'(bus.tx_data), 64'(prev_data));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        xfer_cnt++;
        check("byte_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check("tx_byte", 64'(bus.tx_data), 64'(exp_q.pop_front()));
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int x0;
    bus.cmd_valid = 1'b0;
    bus.cmd_type  = 2'b00;
    bus.cmd_id    = 2'b00;
    bus.cmd_index = 4'd0;
    bus.cmd_value = 64'd0;

    #12;
    check("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_tx_data", 64'(bus.tx_data), 64'h00);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(bus.cmd_ready), 64'd1);

    // 'b' frame, no stalls: 16 bytes back to back starting the cycle after accept
    send_cmd(2'b00, 2'b01, 4'd3, 64'h05, 1'b1);
    for (int i = 0; i < 8 + BIN_W; i++) begin
      @(negedge clk);
      check("b_valid_consec", 64'(bus.tx_valid && bus.tx_ready), 64'd1);
      check("b_busy", 64'(bus.busy), 64'd1);
    end
    @(negedge clk);
    check("b_ready_after", 64'(bus.cmd_ready), 64'd1);
    check("b_busy_after", 64'(bus.busy), 64'd0);
    check("b_queue_empty", 64'(exp_q.size()), 64'd0);

    // 't' frame
    send_cmd(2'b10, 2'b00, 4'd0, 64'd0, 1'b1);
    repeat (2) begin
      @(negedge clk);
      check("t_valid", 64'(bus.tx_valid), 64'd1);
    end
    @(negedge clk);
    check("t_ready_after", 64'(bus.cmd_ready), 64'd1);
    check("t_queue_empty", 64'(exp_q.size()), 64'd0);

`ifdef CMD_TX_FLOAT_EN
    send_cmd(2'b01, 2'b00, 4'd0, 64'd198, 1'b1);
    wait_idle(500);
    send_cmd(2'b01, 2'b00, 4'd0, 64'd0, 1'b1);
    wait_idle(500);
    send_cmd(2'b01, 2'b00, 4'd0, 64'd65535, 1'b1);
    wait_idle(500);
    ready_mode = 2;
    send_cmd(2'b01, 2'b10, 4'd7, 64'($urandom_range(0, 65535)), 1'b1);
    wait_idle(1000);
    ready_mode = 0;
`else
    reject_test(2'b01, 4'd0, "rej_float");
`endif

    // stalled 'b' frames
    ready_mode = 1;
    send_cmd(2'b00, 2'b10, 4'd9, 64'($urandom_range(0, 255)), 1'b1);
    wait_idle(200);
    ready_mode = 2;
    for (int r = 0; r < 3; r++) begin
      send_cmd(2'b00, 2'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
               64'($urandom_range(0, 255)), 1'b1);
      wait_idle(400);
    end
    ready_mode = 0;

    // rejected commands
    reject_test(2'b00, 4'd12, "rej_index");
    reject_test(2'b11, 4'd2, "rej_type");

    // reset in the middle of a 'b' frame
    send_cmd(2'b00, 2'b01, 4'd5, 64'hA5, 1'b1);
    repeat (6) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_ready", 64'(bus.cmd_ready), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    x0 = xfer_cnt;
    send_cmd(2'b10, 2'b00, 4'd0, 64'd0, 1'b1);
    wait_idle(50);
    check("midrst_t_bytes", 64'(xfer_cnt - x0), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
